pipeline_stats_collector: RTL and testbench

//   Counts per-cycle retire, stall and hazard events from a MIPS-Lite simulator model.
//   On halt, freezes the counters and streams them out one word at a time over a

---
 rtl/pipeline_stats_collector_if.sv | 27 ++
 rtl/pipeline_stats_collector.sv | 124 ++++++++++++
 tb/tb_pipeline_stats_collector.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stats_collector_if.sv
// Report stream of the statistics collector: one counter word per transfer
// on a valid/ready handshake.
interface pipeline_stats_collector_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             rpt_valid;
  logic             rpt_ready;
  logic [3:0]       rpt_idx;
  logic [CNT_W-1:0] rpt_data;
  logic             rpt_last;

  modport master (
    output rpt_valid,
    output rpt_idx,
    output rpt_data,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_idx,
    input  rpt_data,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/pipeline_stats_collector.sv
// Per-cycle pipeline event counters; on halt the counters freeze and are
// streamed out as nine indexed words, after which done stays set until reset.
module pipeline_stats_collector #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        run,
  input  logic                        ev_retire,
  input  logic [2:0]                  ev_class,
  input  logic                        ev_br_taken,
  input  logic                        ev_stall,
  input  logic                        ev_raw,
  input  logic                        halt,
  pipeline_stats_collector_if.master  rpt,
  output logic                        done
);

  localparam int unsigned NumCnt = 9;

  typedef enum logic [1:0] {StCount, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NumCnt];
  logic [CNT_W-1:0] cnt_d [NumCnt];
  logic [NumCnt-1:0] inc;

  logic             valid_q, valid_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [3:0]       idx_nxt;

  // Index order: cycles, instr, arith, logic, mem, branch, br_taken, stall, raw.
  always_comb begin
    inc = '0;
    if (state_q == StCount && run) begin
      inc[0] = 1'b1;
      inc[1] = ev_retire;
      inc[2] = ev_retire && (ev_class == 3'd0);
      inc[3] = ev_retire && (ev_class == 3'd1);
      inc[4] = ev_retire && (ev_class == 3'd2);
      inc[5] = ev_retire && (ev_class == 3'd3);
      inc[6] = ev_retire && (ev_class == 3'd3) && ev_br_taken;
      inc[7] = ev_stall;
      inc[8] = ev_raw;
    end
  end

  // Saturating increment: a full counter holds at all-ones.
  always_comb begin
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = (inc[i] && (cnt_q[i] != '1)) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = done_q;
    idx_nxt = idx_q + 4'd1;
    unique case (state_q)
      StCount: begin
        if (halt) begin
          state_d = StDrain;
          valid_d = 1'b1;
          idx_d   = 4'd0;
          // Include the halt cycle's own events in the first word.
          data_d  = cnt_d[0];
          last_d  = 1'b0;
        end
      end
      StDrain: begin
        if (rpt.rpt_ready) begin
          if (last_q) begin
            state_d = StDone;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = cnt_q[idx_nxt];
            last_d = (idx_nxt == 4'd8);
          end
        end
      end
      StDone: ;
      default: state_d = StCount;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StCount;
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_idx   = idx_q;
  assign rpt.rpt_data  = data_q;
  assign rpt.rpt_last  = last_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pipeline_stats_collector.sv
// Scoreboard bench: a 32-bit and a 4-bit collector see identical stimulus; a
// reference model pushes expected report words at halt, popped on each transfer.
module tb_pipeline_stats_collector;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       ev_retire = 1'b0;
  logic [2:0] ev_class = 3'd0;
  logic       ev_br_taken = 1'b0;
  logic       ev_stall = 1'b0;
  logic       ev_raw = 1'b0;
  logic       halt = 1'b0;
  logic       ready = 1'b0;
  logic       done;
  logic       done_s;

  pipeline_stats_collector_if #(.CNT_W(32)) rpt_if ();
  pipeline_stats_collector_if #(.CNT_W(4))  rpt_if_s ();

  assign rpt_if.rpt_ready   = ready;
  assign rpt_if_s.rpt_ready = ready;

  pipeline_stats_collector #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .ev_retire   (ev_retire),
    .ev_class    (ev_class),
    .ev_br_taken (ev_br_taken),
    .ev_stall    (ev_stall),
    .ev_raw      (ev_raw),
    .halt        (halt),
    .rpt         (rpt_if.master),
    .done        (done)
  );

  pipeline_stats_collector #(.CNT_W(4)) dut_s (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .ev_retire   (ev_retire),
    .ev_class    (ev_class),
    .ev_br_taken (ev_br_taken),
    .ev_stall    (ev_stall),
    .ev_raw      (ev_raw),
    .halt        (halt),
    .rpt         (rpt_if_s.master),
    .done        (done_s)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] data;
    logic        last;
  } word_t;

  word_t       sb_q[$];
  word_t       sbs_q[$];
  int unsigned m_cnt[9];
  bit          counting = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int unsigned v, input int unsigned w);
    longint unsigned mx;
    mx = (64'd1 << w) - 1;
    return (longint'(v) > mx) ? mx : 64'(v);
  endfunction

  task automatic push_expected();
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{idx: 4'(i), data: sat(m_cnt[i], 32), last: (i == 8)});
      sbs_q.push_back('{idx: 4'(i), data: sat(m_cnt[i], 4), last: (i == 8)});
    end
  endtask

  // Drive one cycle of inputs, update the model, then advance past the edge.
  task automatic step(input bit r, input bit ret, input logic [2:0] cls, input bit br,
                      input bit st, input bit rw, input bit h);
    run = r; ev_retire = ret; ev_class = cls; ev_br_taken = br;
    ev_stall = st; ev_raw = rw; halt = h;
    if (counting) begin
      if (r) begin
        m_cnt[0]++;
        if (ret) begin
          m_cnt[1]++;
          case (cls)
            3'd0: m_cnt[2]++;
            3'd1: m_cnt[3]++;
            3'd2: m_cnt[4]++;
            3'd3: begin
              m_cnt[5]++;
              if (br) m_cnt[6]++;
            end
            default: ;
          endcase
        end
        if (st) m_cnt[7]++;
        if (rw) m_cnt[8]++;
      end
      if (h) begin
        push_expected();
        counting = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step_noise();
    step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
         $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ready = 1'b0;
    run = 0; ev_retire = 0; ev_class = 0; ev_br_taken = 0; ev_stall = 0; ev_raw = 0; halt = 0;
    sb_q.delete();
    sbs_q.delete();
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    counting = 1'b1;
    #1;
    check("rst_valid", rpt_if.rpt_valid, 0);
    check("rst_idx", rpt_if.rpt_idx, 0);
    check("rst_data", rpt_if.rpt_data, 0);
    check("rst_last", rpt_if.rpt_last, 0);
    check("rst_done", done, 0);
    check("rst_s_valid", rpt_if_s.rpt_valid, 0);
    check("rst_s_done", done_s, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Drain the report; optionally hold ready low 3 cycles at hold_idx, or randomise
  // ready and keep injecting events/halt to show they are ignored.
  task automatic drain(input int hold_idx, input bit noisy);
    int holds = 3;
    int budget = 300;
    while (sb_q.size() != 0 && budget > 0) begin
      if (hold_idx >= 0 && int'(rpt_if.rpt_idx) == hold_idx && holds > 0) begin
        ready = 1'b0;
        holds--;
      end else if (noisy) begin
        ready = $urandom_range(0, 1) == 1;
      end else begin
        ready = 1'b1;
      end
      if (noisy) step_noise();
      else step(0, 0, 3'd0, 0, 0, 0, 0);
      budget--;
    end
    if (budget == 0) check("drain_timeout_words_left", 64'(sb_q.size()), 0);
    ready = 1'b0;
    step(0, 0, 3'd0, 0, 0, 0, 0);
    check("drain_done", done, 1);
    check("drain_s_done", done_s, 1);
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  bit          prev_hold = 1'b0;
  bit          exp_done_next = 1'b0;
  logic [3:0]  prev_idx;
  logic [31:0] prev_data;
  logic        prev_last;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_hold = 1'b0;
        exp_done_next = 1'b0;
      end else begin
        if (counting) check("valid_while_counting", rpt_if.rpt_valid, 0);
        if (exp_done_next) begin
          check("done_after_last", done, 1);
          check("valid_after_last", rpt_if.rpt_valid, 0);
          check("s_done_after_last", done_s, 1);
          exp_done_next = 1'b0;
        end
        if (prev_hold) begin
          check("hold_idx", rpt_if.rpt_idx, prev_idx);
          check("hold_data", rpt_if.rpt_data, prev_data);
          check("hold_last", rpt_if.rpt_last, prev_last);
          check("hold_valid", rpt_if.rpt_valid, 1);
        end
        prev_hold = rpt_if.rpt_valid && !ready;
        prev_idx  = rpt_if.rpt_idx;
        prev_data = rpt_if.rpt_data;
        prev_last = rpt_if.rpt_last;
        if (rpt_if.rpt_valid && ready) begin
          if (sb_q.size() == 0 || sbs_q.size() == 0) begin
            check("spurious_word", 1, 0);
          end else begin
            word_t e, es;
            e  = sb_q.pop_front();
            es = sbs_q.pop_front();
            check("word_idx", rpt_if.rpt_idx, e.idx);
            check("word_data", rpt_if.rpt_data, e.data);
            check("word_last", rpt_if.rpt_last, e.last);
            check("s_word_idx", rpt_if_s.rpt_idx, es.idx);
            check("s_word_data", rpt_if_s.rpt_data, es.data);
            check("s_word_last", rpt_if_s.rpt_last, es.last);
            check("s_word_valid", rpt_if_s.rpt_valid, 1);
            if (e.last) exp_done_next = 1'b1;
          end
        end
      end
    end
  end

  // Reference run: class, br_taken, stall, raw per cycle; every cycle retires.
  logic [2:0] t1_cls [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd5};
  bit         t1_br  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  bit         t1_st  [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  bit         t1_rw  [10] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};

  task automatic ref_run();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, t1_cls[i], t1_br[i], t1_st[i], t1_rw[i], i == 9);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reference run, ready always high
    do_reset();
    ref_run();
    drain(-1, 0);

    // 2: same run, backpressure while idx 2 is shown
    do_reset();
    ref_run();
    drain(2, 0);

    // 3: 20 stall cycles, halt in a separate idle cycle; 4-bit copy saturates
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 3'd0, 0, 1, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0, 1);
    drain(-1, 0);

    // 4: br_taken on non-branch classes is ignored; noise during drain
    do_reset();
    step(1, 1, 3'd0, 1, 0, 0, 0);
    step(1, 1, 3'd4, 1, 0, 1, 0);
    step(1, 1, 3'd3, 0, 1, 0, 0);
    step(0, 1, 3'd3, 1, 1, 1, 0);
    step(1, 1, 3'd1, 1, 0, 0, 1);
    drain(-1, 1);

    // 5: reset in the middle of a drain, then a short rerun
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 1, 3'(i), 0, 1, 1, i == 6);
    ready = 1'b1;
    repeat (4) step(0, 0, 3'd0, 0, 0, 0, 0);
    check("mid_drain_idx", rpt_if.rpt_idx, 4);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 3'd0, 0, 0, 0, i == 4);
    drain(-1, 0);

    // 6: halt with run low at the first cycle, then done must stay up
    do_reset();
    step(0, 1, 3'd3, 1, 1, 1, 1);
    drain(-1, 0);
    for (int i = 0; i < 50; i++) begin
      ready = $urandom_range(0, 1) == 1;
      step_noise();
      check("done_sticky", done, 1);
      check("done_valid_low", rpt_if.rpt_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
